// File: rtl/imm_gen_pkg.sv
// Shared types for the pipelined RISC-V immediate generator: opcodes, format codes, buffer entry.
// The optional IMM_GEN_PERF_EN counters need nothing from this package.
package imm_gen_pkg;

    localparam int IMM_MAX_W = 64;
    localparam int TAG_MAX_W = 64;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_FMT_R = 3'd0,
        IMM_FMT_I = 3'd1,
        IMM_FMT_S = 3'd2,
        IMM_FMT_B = 3'd3,
        IMM_FMT_U = 3'd4,
        IMM_FMT_J = 3'd5
    } imm_fmt_e;

    // Sized for the widest build; the top level slices down to XLEN/TAG_W.
    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        imm_fmt_e             fmt;
        logic                 illegal;
        logic [TAG_MAX_W-1:0] tag;
    } imm_entry_t;

endpackage

// File: rtl/imm_gen_if.sv
// Valid/ready bus of the immediate generator: instruction+tag in, decoded immediate+tag out.
// Optional IMM_GEN_PERF_EN counters are plain ports on the top, not part of this bus.
interface imm_gen_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) ();
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      Instruction32;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  Imm_out;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output flush, in_valid, Instruction32, in_tag, out_ready,
        input  in_ready, out_valid, Imm_out, out_fmt, out_illegal, out_tag
    );

    modport slave (
        input  flush, in_valid, Instruction32, in_tag, out_ready,
        output in_ready, out_valid, Imm_out, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decode: opcode -> format, illegal flag, sign-extended imm.
// Unaffected by IMM_GEN_PERF_EN.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]            instr,
    output logic signed [XLEN-1:0] imm,
    output imm_fmt_e               fmt,
    output logic                   illegal
);

    logic [6:0]         opcode;
    logic signed [31:0] imm32;

    assign opcode = instr[6:0];

    always_comb begin
        imm32   = '0;
        fmt     = IMM_FMT_R;
        illegal = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin
                fmt   = IMM_FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_OP_IMM_32: begin
                // Word-sized ops only exist on RV64.
                if (XLEN == 64) begin
                    fmt   = IMM_FMT_I;
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                fmt   = IMM_FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                fmt   = IMM_FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt   = IMM_FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt   = IMM_FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_OP: ;
            OPC_OP_32: illegal = (XLEN != 64);
            default:   illegal = 1'b1;
        endcase
    end

    // imm32 is signed, so widening to 64 replicates bit 31.
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode on entry, 2-entry skid buffer with valid/ready handshake.
// Define IMM_GEN_PERF_EN to add saturating perf_accepted/perf_illegal counters.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    imm_gen_if.slave    bus
`ifdef IMM_GEN_PERF_EN
    ,
    output logic [31:0] perf_accepted,
    output logic [31:0] perf_illegal
`endif
);

    logic signed [XLEN-1:0] dec_imm;
    imm_fmt_e               dec_fmt;
    logic                   dec_illegal;
    imm_entry_t             in_ent;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (bus.Instruction32),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign in_ent = '{imm:     IMM_MAX_W'(dec_imm),
                      fmt:     dec_fmt,
                      illegal: dec_illegal,
                      tag:     TAG_MAX_W'(bus.in_tag)};

    // ---- stage p0: head entry (drives the outputs), p1: skid entry ----
    logic [1:0] cnt;
    imm_entry_t ent_p0;
    imm_entry_t ent_p1;
    logic       push;
    logic       pop;

    assign bus.in_ready  = (cnt < 2'd2);
    assign bus.out_valid = (cnt != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= 2'd0;
            ent_p0 <= '0;
            ent_p1 <= '0;
        end else if (bus.flush) begin
            cnt <= 2'd0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (push) begin
                        ent_p0 <= in_ent;
                        cnt    <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, pop})
                        2'b11: ent_p0 <= in_ent;
                        2'b10: begin
                            ent_p1 <= in_ent;
                            cnt    <= 2'd2;
                        end
                        2'b01: cnt <= 2'd0;
                        default: ;
                    endcase
                end
                default: begin
                    // Full: in_ready is low, so only a pop can happen.
                    if (pop) begin
                        ent_p0 <= ent_p1;
                        cnt    <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign bus.Imm_out     = ent_p0.imm[XLEN-1:0];
    assign bus.out_fmt     = ent_p0.fmt;
    assign bus.out_illegal = ent_p0.illegal;
    assign bus.out_tag     = ent_p0.tag[TAG_W-1:0];

    logic unused_hi;
    assign unused_hi = ^{ent_p0.imm, ent_p0.tag};

`ifdef IMM_GEN_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    // Counters track handshakes, so a push in a flush cycle still counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_accepted <= '0;
            perf_illegal  <= '0;
        end else begin
            perf_accepted <= sat_inc(perf_accepted, push);
            perf_illegal  <= sat_inc(perf_illegal, push && dec_illegal);
        end
    end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances, directed vectors.
// With IMM_GEN_PERF_EN defined the perf counters are checked as well.
module tb_imm_gen_pipe;
    logic clk;
    logic reset;

    imm_gen_if #(.XLEN(32), .TAG_W(32)) bus32 ();
    imm_gen_if #(.XLEN(64), .TAG_W(32)) bus64 ();

`ifdef IMM_GEN_PERF_EN
    logic [31:0] pa32, pi32, pa64, pi64;
`endif

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk (clk), .reset (reset), .bus (bus32)
`ifdef IMM_GEN_PERF_EN
        , .perf_accepted (pa32), .perf_illegal (pi32)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk (clk), .reset (reset), .bus (bus64)
`ifdef IMM_GEN_PERF_EN
        , .perf_accepted (pa64), .perf_illegal (pi64)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    int n_vec = 0;
    int n_err = 0;

    // Expectation flags raised by the stimulus for one cycle.
    bit chk_zero, chk_vld, exp_vld, chk_rdy, exp_rdy, chk_perf, chk_empty, tmo_flag;
    int acc_cnt = 0;
    int ill_cnt = 0;

    task automatic check(input string name, input bit ok, input string act, input string exp);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %s, want %s", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever an output handshake is about to happen.
    bit          prev_v, prev_rdy, prev_flush, prev_rst, tmo_seen;
    logic [31:0] prev_imm, prev_tag;
    logic [2:0]  prev_fmt;
    logic        prev_ill;

    always @(negedge clk) begin : mon
        exp_t e;
        if (chk_zero)
            check("reset_state",
                  !bus32.out_valid && bus32.in_ready && bus32.Imm_out == 0 && bus32.out_fmt == 0
                  && !bus32.out_illegal && bus32.out_tag == 0,
                  $sformatf("v=%0b rdy=%0b imm=%h fmt=%0d ill=%0b tag=%h", bus32.out_valid,
                            bus32.in_ready, bus32.Imm_out, bus32.out_fmt, bus32.out_illegal, bus32.out_tag),
                  "v=0 rdy=1 imm=0 fmt=0 ill=0 tag=0");
        if (chk_vld)
            check("out_valid", bus32.out_valid == exp_vld,
                  $sformatf("%0b", bus32.out_valid), $sformatf("%0b", exp_vld));
        if (chk_rdy)
            check("in_ready", bus32.in_ready == exp_rdy,
                  $sformatf("%0b", bus32.in_ready), $sformatf("%0b", exp_rdy));
        if (tmo_flag && !tmo_seen) begin
            tmo_seen = 1'b1;
            check("push_timeout", 1'b0, "no in_ready", "in_ready within budget");
        end
`ifdef IMM_GEN_PERF_EN
        if (chk_perf)
            check("perf", pa32 == acc_cnt && pi32 == ill_cnt,
                  $sformatf("acc=%0d ill=%0d", pa32, pi32), $sformatf("acc=%0d ill=%0d", acc_cnt, ill_cnt));
`endif
        if (chk_empty)
            check("drained", q32.size() == 0 && q64.size() == 0,
                  $sformatf("%0d/%0d left", q32.size(), q64.size()), "0/0 left");

        if (!reset && !prev_rst && prev_v && !prev_rdy && !prev_flush)
            check("hold_stable",
                  bus32.out_valid && bus32.Imm_out == prev_imm && bus32.out_fmt == prev_fmt
                  && bus32.out_illegal == prev_ill && bus32.out_tag == prev_tag,
                  $sformatf("v=%0b imm=%h tag=%h", bus32.out_valid, bus32.Imm_out, bus32.out_tag),
                  $sformatf("v=1 imm=%h tag=%h", prev_imm, prev_tag));

        if (!reset && bus32.out_valid && bus32.out_ready && !bus32.flush) begin
            if (q32.size() == 0) begin
                check("out32_unexpected", 1'b0, $sformatf("tag=%h", bus32.out_tag), "no output");
            end else begin
                e = q32.pop_front();
                check("out32",
                      bus32.Imm_out == e.imm[31:0] && bus32.out_fmt == e.fmt
                      && bus32.out_illegal == e.ill && bus32.out_tag == e.tag,
                      $sformatf("imm=%h fmt=%0d ill=%0b tag=%h", bus32.Imm_out, bus32.out_fmt,
                                bus32.out_illegal, bus32.out_tag),
                      $sformatf("imm=%h fmt=%0d ill=%0b tag=%h", e.imm[31:0], e.fmt, e.ill, e.tag));
            end
        end

        if (!reset && bus64.out_valid && bus64.out_ready) begin
            if (q64.size() == 0) begin
                check("out64_unexpected", 1'b0, $sformatf("tag=%h", bus64.out_tag), "no output");
            end else begin
                e = q64.pop_front();
                check("out64",
                      bus64.Imm_out == e.imm && bus64.out_fmt == e.fmt
                      && bus64.out_illegal == e.ill && bus64.out_tag == e.tag,
                      $sformatf("imm=%h fmt=%0d ill=%0b tag=%h", bus64.Imm_out, bus64.out_fmt,
                                bus64.out_illegal, bus64.out_tag),
                      $sformatf("imm=%h fmt=%0d ill=%0b tag=%h", e.imm, e.fmt, e.ill, e.tag));
            end
        end

        prev_v     = bus32.out_valid;
        prev_rdy   = bus32.out_ready;
        prev_flush = bus32.flush;
        prev_rst   = reset;
        prev_imm   = bus32.Imm_out;
        prev_fmt   = bus32.out_fmt;
        prev_ill   = bus32.out_illegal;
        prev_tag   = bus32.out_tag;
    end

    task automatic send32(input logic [31:0] ins, input logic [31:0] tag,
                          input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
        bit acc = 1'b0;
        bus32.in_valid      = 1'b1;
        bus32.Instruction32 = ins;
        bus32.in_tag        = tag;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = bus32.in_ready;
            @(posedge clk);
            #1;
        end
        if (acc) begin
            q32.push_back('{imm, fmt, ill, tag});
            acc_cnt++;
            if (ill) ill_cnt++;
        end else begin
            tmo_flag = 1'b1;
        end
        bus32.in_valid = 1'b0;
    endtask

    task automatic send64(input logic [31:0] ins, input logic [31:0] tag,
                          input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
        bit acc = 1'b0;
        bus64.in_valid      = 1'b1;
        bus64.Instruction32 = ins;
        bus64.in_tag        = tag;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = bus64.in_ready;
            @(posedge clk);
            #1;
        end
        if (acc) q64.push_back('{imm, fmt, ill, tag});
        else     tmo_flag = 1'b1;
        bus64.in_valid = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.Instruction32 = '0;
        bus32.in_tag = '0;  bus32.out_ready = 1'b1;
        bus64.flush = 1'b0; bus64.in_valid = 1'b0; bus64.Instruction32 = '0;
        bus64.in_tag = '0;  bus64.out_ready = 1'b1;
        chk_zero = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk_zero = 1'b0;

        // Single branch, one-cycle latency.
        send32(32'hFE000EE3, 32'h100, 64'hFFFFFFFC, 3'd3, 1'b0);
        chk_vld = 1'b1; exp_vld = 1'b1;
        tick();
        chk_vld = 1'b0;
        tick();

        // Back-to-back I, U, J, S.
        send32(32'hFFF00093, 32'h101, 64'hFFFFFFFF, 3'd1, 1'b0);
        send32(32'h123450B7, 32'h102, 64'h12345000, 3'd4, 1'b0);
        send32(32'h0080006F, 32'h103, 64'h00000008, 3'd5, 1'b0);
        send32(32'hFE20AC23, 32'h104, 64'hFFFFFFF8, 3'd2, 1'b0);
        repeat (3) tick();

        // Backpressure: two fill the buffer, the third waits for a slot.
        bus32.out_ready = 1'b0;
        send32(32'h00500113, 32'h200, 64'h00000005, 3'd1, 1'b0);
        send32(32'h00C0006F, 32'h201, 64'h0000000C, 3'd5, 1'b0);
        bus32.in_valid = 1'b1; bus32.Instruction32 = 32'h000012B7; bus32.in_tag = 32'h202;
        chk_rdy = 1'b1; exp_rdy = 1'b0;
        repeat (3) tick();
        chk_rdy = 1'b0;
        bus32.out_ready = 1'b1;
        send32(32'h000012B7, 32'h202, 64'h00001000, 3'd4, 1'b0);
        repeat (4) tick();

        // Illegal and R-type, including RV64-only opcodes on XLEN=32.
        send32(32'h0000007F, 32'h300, 64'h0, 3'd0, 1'b1);
        send32(32'h002081B3, 32'h301, 64'h0, 3'd0, 1'b0);
        send32(32'hFFF0001B, 32'h302, 64'h0, 3'd0, 1'b1);
        send32(32'h0000003B, 32'h303, 64'h0, 3'd0, 1'b1);

        // XLEN=64 instance.
        send64(32'hFFF00093, 32'h400, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        send64(32'h800000B7, 32'h401, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
        send64(32'hFFF0001B, 32'h402, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        send64(32'h0000003B, 32'h403, 64'h0, 3'd0, 1'b0);
        repeat (4) tick();

        // Flush with two buffered, plus attempted push and pop in the same cycle.
        bus32.out_ready = 1'b0;
        send32(32'hFFF00093, 32'h500, 64'hFFFFFFFF, 3'd1, 1'b0);
        send32(32'h123450B7, 32'h501, 64'h12345000, 3'd4, 1'b0);
        bus32.flush = 1'b1; bus32.in_valid = 1'b1; bus32.Instruction32 = 32'h0080006F;
        bus32.in_tag = 32'h502; bus32.out_ready = 1'b1;
        tick();
        bus32.flush = 1'b0; bus32.in_valid = 1'b0;
        q32.delete();
        chk_vld = 1'b1; exp_vld = 1'b0;
        tick();
        chk_vld = 1'b0;

        // Flush with one buffered and an accepted push in the same cycle.
        bus32.out_ready = 1'b0;
        send32(32'hFE000EE3, 32'h600, 64'hFFFFFFFC, 3'd3, 1'b0);
        bus32.flush = 1'b1; bus32.in_valid = 1'b1; bus32.Instruction32 = 32'h0000007F;
        bus32.in_tag = 32'h601;
        acc_cnt++; ill_cnt++;
        tick();
        bus32.flush = 1'b0; bus32.in_valid = 1'b0;
        q32.delete();
        chk_vld = 1'b1; exp_vld = 1'b0; chk_perf = 1'b1;
        tick();
        chk_vld = 1'b0; chk_perf = 1'b0;

        // Asynchronous reset mid-stream with two entries buffered.
        send32(32'hFFF00093, 32'h700, 64'hFFFFFFFF, 3'd1, 1'b0);
        send32(32'hFE20AC23, 32'h701, 64'hFFFFFFF8, 3'd2, 1'b0);
        reset = 1'b1;
        q32.delete(); q64.delete();
        acc_cnt = 0; ill_cnt = 0;
        chk_zero = 1'b1; chk_perf = 1'b1;
        tick();
        chk_zero = 1'b0; chk_perf = 1'b0;
        reset = 1'b0;
        bus32.out_ready = 1'b1;
        tick();

        send32(32'h0080006F, 32'h800, 64'h00000008, 3'd5, 1'b0);
        for (int i = 0; i < 40 && (q32.size() != 0 || q64.size() != 0); i++) tick();
        chk_empty = 1'b1; chk_perf = 1'b1;
        tick();
        chk_empty = 1'b0; chk_perf = 1'b0;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator; successor to the single-format combinational B-type generator.
- Decodes all RV32I/RV64I immediate formats (I, S, B, U, J) from the opcode and sign-extends to XLEN.
- Sits between fetch and the decode/ALU stage and carries a PC/tag sideband.
- Uses a valid/ready handshake with a 2-entry skid buffer so downstream backpressure never drops instructions.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64.
TAG_W, 32, width of the sideband tag (typically the PC) passed through unchanged.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
flush  in  1  synchronous clear of all buffered entries.
in_valid  in  1  Instruction32/in_tag are valid.
in_ready  out  1  block can accept an input this cycle.
Instruction32  in  32  raw instruction word.
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  Imm_out/out_fmt/out_illegal/out_tag are valid.
out_ready  in  1  consumer accepts the output this cycle.
Imm_out  out  XLEN  sign-extended immediate.
out_fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5.
out_illegal  out  1  opcode is not recognised.
out_tag  out  TAG_W  tag of the current output entry.

Behaviour:
- Reset is asynchronous, active-high.
  - Reset clears the buffer count to 0, so out_valid=0 and in_ready=1.
  - Imm_out, out_fmt, out_illegal and out_tag reset to 0.
  - Reset mid-stream discards all entries.
- Handshakes:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count < 2); it is registered-derived, with no combinational path from out_ready.
  - out_valid = (count != 0).
  - Output fields come from the head entry and are stable while out_valid && !out_ready.
- Latency: an accepted instruction appears at the output on the next cycle when the buffer was empty, or behind any earlier entries. Order is strictly FIFO.
- Simultaneous events:
  - count=1, push+pop: count stays 1; the new entry becomes the head next cycle.
  - count=2: no push possible; a pop frees a slot and in_ready=1 next cycle.
  - flush: count→0 next cycle and overrides a push and a pop in the same cycle. Output data registers keep their values; only valid drops.
- Decode is combinational on the input, and the result is stored in the entry. opcode = Instruction32[6:0].
  - 0000011, 0010011, 1100111, 1110011 → I; 0011011 → I only when XLEN=64. imm = sext(ins[31:20]).
  - 0100011 → S; imm = sext({ins[31:25], ins[11:7]}).
  - 1100011 → B; imm = sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}).
  - 0110111, 0010111 → U; imm = sext({ins[31:12], 12'b0}), sign-extended above bit 31 when XLEN=64.
  - 1101111 → J; imm = sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}).
  - 0110011, 0111011 (the latter only when XLEN=64) → R; imm = 0, illegal = 0.
  - Any other opcode → fmt = R, imm = 0, illegal = 1.
- Shift-amount handling is left to the ALU; I-type immediates are always sign-extended.

Optional Feature:
- Macro: IMM_GEN_PERF_EN.
- When defined:
  - Adds 32-bit saturating counters perf_accepted and perf_illegal as outputs.
  - perf_accepted increments on each push; perf_illegal increments on each push with the illegal flag set.
  - Both counters are cleared by reset and not by flush, and saturate at 0xFFFFFFFF.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package imm_gen_pkg holds:
  - opcode localparams;
  - the fmt encoding (IMM_FMT_R..IMM_FMT_J);
  - the entry struct {imm, fmt, illegal, tag}.
- One sub-module: imm_decode, the purely combinational opcode→format/immediate function parametrised by XLEN. The top level holds only the skid buffer and handshake.

Test Plan:
- XLEN=32, out_ready=1: push 0xFE000EE3 (beq -4) → next cycle out_valid=1, Imm_out=0xFFFFFFFC, out_fmt=3.
- Back-to-back push of 0xFFF00093, 0x123450B7, 0x0080006F, 0xFE20AC23 → Imm_out 0xFFFFFFFF(I), 0x12345000(U), 0x00000008(J), 0xFFFFFFF8(S), in order with matching tags.
- Hold out_ready=0 and push 3 instructions → in_ready drops after 2 pushes, the third is held by the source, the head output stays stable; release → all 3 drain in order with no loss.
- Push 0x0000007F → out_illegal=1, Imm_out=0, out_fmt=0.
- XLEN=64: 0xFFF00093 → Imm_out=0xFFFFFFFFFFFFFFFF; 0x800000B7 → 0xFFFFFFFF80000000.
- With 2 entries buffered, assert flush plus a push in the same cycle → out_valid=0 next cycle; assert reset mid-stream → outputs 0 immediately (async). With IMM_GEN_PERF_EN, perf counts are correct after this sequence.
